// File: rtl/ofs_plat_host_chan_tie_off_pkg.sv
// ---------------------------------------------------------------------------
// ofs_plat_host_chan_tie_off_pkg
//
// Purpose: shared definitions for the CCI-P host channel tie-off.
//   - DFH_NULL_AFU   : default device feature header (type AFU, EOL=1, next=0)
//   - TID_W/ADDR_W/DATA_W : CCI-P MMIO request/response field widths
//   - rsp_entry_t    : one slot of the fixed-latency MMIO response pipeline
//   - is_dfh_addr()  : true when a DWORD address hits the 64-bit DFH register
// ---------------------------------------------------------------------------
package ofs_plat_host_chan_tie_off_pkg;

  localparam int TID_W  = 9;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;

  localparam logic [DATA_W-1:0] DFH_NULL_AFU = 64'h1000_0100_0000_0000;

  typedef struct packed {
    logic              valid;
    logic [TID_W-1:0]  tid;
    logic [DATA_W-1:0] data;
  } rsp_entry_t;

  // The DFH is a 64-bit register, so both DWORD 0 and DWORD 1 select it.
  function automatic logic is_dfh_addr(input logic [ADDR_W-1:0] addr);
    return (addr[ADDR_W-1:1] == 15'd0);
  endfunction

endpackage

// File: rtl/ofs_plat_host_chan_ccip_tie_off_port.sv
// ---------------------------------------------------------------------------
// ofs_plat_host_chan_ccip_tie_off_port
//
// Purpose: ties off one native CCI-P host channel. Memory request channels
// c0/c1 are held idle; every MMIO read is answered on c2 exactly RSP_LATENCY
// cycles after the request through a shift register with RSP_LATENCY slots,
// so back-to-back reads need no flow control.
//
// Optional statistics (macro OFS_PLAT_HOST_CHAN_TIE_OFF_STATS_EN): saturating
// read/write/stray-response counters and a sticky protocol-error flag. With
// the macro undefined the statistics outputs are constant 0 and no counter
// flops exist.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_c0_mmio_rd_valid/wr_valid MMIO read / write request strobes
//   i_c0_tid, i_c0_addr        MMIO request header (tid, DWORD address)
//   i_c0_rsp_valid, i_c1_rsp_valid  memory responses (never expected)
//   o_c0_valid, o_c1_valid     memory request valids (always 0)
//   o_c2_mmio_rd_valid/tid/data  registered MMIO read response
//   o_mmio_rd_cnt, o_mmio_wr_cnt, o_stray_rsp_cnt, o_proto_err  statistics
// ---------------------------------------------------------------------------
module ofs_plat_host_chan_ccip_tie_off_port
  import ofs_plat_host_chan_tie_off_pkg::*;
#(
  parameter int                RSP_LATENCY     = 2,
  parameter logic [DATA_W-1:0] DFH_VALUE       = DFH_NULL_AFU,
  parameter logic [DATA_W-1:0] DEFAULT_RD_DATA = 64'h0,
  parameter int                CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_c0_mmio_rd_valid,
  input  logic                 i_c0_mmio_wr_valid,
  input  logic [TID_W-1:0]     i_c0_tid,
  input  logic [ADDR_W-1:0]    i_c0_addr,
  input  logic                 i_c0_rsp_valid,
  input  logic                 i_c1_rsp_valid,
  output logic                 o_c0_valid,
  output logic                 o_c1_valid,
  output logic                 o_c2_mmio_rd_valid,
  output logic [TID_W-1:0]     o_c2_tid,
  output logic [DATA_W-1:0]    o_c2_data,
  output logic [CNT_WIDTH-1:0] o_mmio_rd_cnt,
  output logic [CNT_WIDTH-1:0] o_mmio_wr_cnt,
  output logic [CNT_WIDTH-1:0] o_stray_rsp_cnt,
  output logic                 o_proto_err
);

  rsp_entry_t r_pipe [RSP_LATENCY];
  rsp_entry_t w_new_entry;

  // No memory requests are ever issued.
  assign o_c0_valid = 1'b0;
  assign o_c1_valid = 1'b0;

  // Build the response entry for this cycle; idle slots carry zero tid/data
  // so c2 hdr/data read 0 whenever no response is being presented.
  always_comb begin
    w_new_entry = '0;
    if (i_c0_mmio_rd_valid) begin
      w_new_entry.valid = 1'b1;
      w_new_entry.tid   = i_c0_tid;
      if (is_dfh_addr(i_c0_addr)) begin
        w_new_entry.data = DFH_VALUE;
      end else begin
        w_new_entry.data = DEFAULT_RD_DATA;
      end
    end else begin
      w_new_entry = '0;
    end
  end

  // Fixed-latency response shift register; reset drops in-flight responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RSP_LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_new_entry;
      for (int i = 1; i < RSP_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // c2 is driven straight from the last pipeline flop.
  assign o_c2_mmio_rd_valid = r_pipe[RSP_LATENCY-1].valid;
  assign o_c2_tid           = r_pipe[RSP_LATENCY-1].tid;
  assign o_c2_data          = r_pipe[RSP_LATENCY-1].data;

`ifdef OFS_PLAT_HOST_CHAN_TIE_OFF_STATS_EN
  logic [CNT_WIDTH-1:0] r_rd_cnt;
  logic [CNT_WIDTH-1:0] r_wr_cnt;
  logic [CNT_WIDTH-1:0] r_stray_cnt;
  logic                 r_proto_err;
  logic [1:0]           w_stray_inc;

  // Saturating add: the extra carry bit detects overflow, which clamps to all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [1:0]           inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + (CNT_WIDTH+1)'(inc);
    if (sum[CNT_WIDTH]) begin
      return '1;
    end else begin
      return sum[CNT_WIDTH-1:0];
    end
  endfunction

  // A c0 and a c1 stray response in the same cycle count as two.
  assign w_stray_inc = {1'b0, i_c0_rsp_valid} + {1'b0, i_c1_rsp_valid};

  // Statistics counters and sticky protocol-error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_stray_cnt <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_rd_cnt    <= sat_add(r_rd_cnt,    {1'b0, i_c0_mmio_rd_valid});
      r_wr_cnt    <= sat_add(r_wr_cnt,    {1'b0, i_c0_mmio_wr_valid});
      r_stray_cnt <= sat_add(r_stray_cnt, w_stray_inc);
      r_proto_err <= r_proto_err | i_c0_rsp_valid | i_c1_rsp_valid;
    end
  end

  assign o_mmio_rd_cnt   = r_rd_cnt;
  assign o_mmio_wr_cnt   = r_wr_cnt;
  assign o_stray_rsp_cnt = r_stray_cnt;
  assign o_proto_err     = r_proto_err;
`else
  // Statistics compiled out: outputs stay as ports, driven constant 0.
  logic w_unused_ok;
  assign w_unused_ok     = &{1'b0, i_c0_mmio_wr_valid, i_c0_rsp_valid, i_c1_rsp_valid};
  assign o_mmio_rd_cnt   = '0;
  assign o_mmio_wr_cnt   = '0;
  assign o_stray_rsp_cnt = '0;
  assign o_proto_err     = 1'b0;
`endif

endmodule

// File: rtl/ofs_plat_host_chan_ccip_multi_tie_off.sv
// ---------------------------------------------------------------------------
// ofs_plat_host_chan_ccip_multi_tie_off
//
// Purpose: ties off NUM_PORTS unused native CCI-P host channels on the FIU
// side. Each channel is handled by an independent
// ofs_plat_host_chan_ccip_tie_off_port instance: no memory requests, every
// MMIO read answered (DWORD 0/1 -> DFH_VALUE, else DEFAULT_RD_DATA) after
// RSP_LATENCY cycles, MMIO writes absorbed.
//
// The CCI-P channel of each port is carried as flattened per-port fields
// (index p selects the port).
//
// Optional statistics: define OFS_PLAT_HOST_CHAN_TIE_OFF_STATS_EN to build
// the per-port counters and proto_err; otherwise they read constant 0.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   i_rx_c0_mmio_rd_valid[p]     MMIO read request
//   i_rx_c0_mmio_wr_valid[p]     MMIO write request (data discarded)
//   i_rx_c0_tid[p], i_rx_c0_addr[p]  MMIO request header
//   i_rx_c0_rsp_valid[p], i_rx_c1_rsp_valid[p]  stray memory responses
//   o_tx_c0_valid[p], o_tx_c1_valid[p]  memory request valids (always 0)
//   o_tx_c2_mmio_rd_valid[p], o_tx_c2_tid[p], o_tx_c2_data[p]  MMIO response
//   mmio_rd_cnt[p], mmio_wr_cnt[p], stray_rsp_cnt[p], proto_err[p]  statistics
// ---------------------------------------------------------------------------
module ofs_plat_host_chan_ccip_multi_tie_off
  import ofs_plat_host_chan_tie_off_pkg::*;
#(
  parameter int                NUM_PORTS       = 1,
  parameter int                RSP_LATENCY     = 2,
  parameter logic [DATA_W-1:0] DFH_VALUE       = DFH_NULL_AFU,
  parameter logic [DATA_W-1:0] DEFAULT_RD_DATA = 64'h0,
  parameter int                CNT_WIDTH       = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                i_rx_c0_mmio_rd_valid,
  input  logic [NUM_PORTS-1:0]                i_rx_c0_mmio_wr_valid,
  input  logic [NUM_PORTS-1:0][TID_W-1:0]     i_rx_c0_tid,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    i_rx_c0_addr,
  input  logic [NUM_PORTS-1:0]                i_rx_c0_rsp_valid,
  input  logic [NUM_PORTS-1:0]                i_rx_c1_rsp_valid,
  output logic [NUM_PORTS-1:0]                o_tx_c0_valid,
  output logic [NUM_PORTS-1:0]                o_tx_c1_valid,
  output logic [NUM_PORTS-1:0]                o_tx_c2_mmio_rd_valid,
  output logic [NUM_PORTS-1:0][TID_W-1:0]     o_tx_c2_tid,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]    o_tx_c2_data,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] mmio_rd_cnt,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] mmio_wr_cnt,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] stray_rsp_cnt,
  output logic [NUM_PORTS-1:0]                proto_err
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ofs_plat_host_chan_ccip_tie_off_port #(
      .RSP_LATENCY     (RSP_LATENCY),
      .DFH_VALUE       (DFH_VALUE),
      .DEFAULT_RD_DATA (DEFAULT_RD_DATA),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_port (
      .clk                (clk),
      .reset              (reset),
      .i_c0_mmio_rd_valid (i_rx_c0_mmio_rd_valid[p]),
      .i_c0_mmio_wr_valid (i_rx_c0_mmio_wr_valid[p]),
      .i_c0_tid           (i_rx_c0_tid[p]),
      .i_c0_addr          (i_rx_c0_addr[p]),
      .i_c0_rsp_valid     (i_rx_c0_rsp_valid[p]),
      .i_c1_rsp_valid     (i_rx_c1_rsp_valid[p]),
      .o_c0_valid         (o_tx_c0_valid[p]),
      .o_c1_valid         (o_tx_c1_valid[p]),
      .o_c2_mmio_rd_valid (o_tx_c2_mmio_rd_valid[p]),
      .o_c2_tid           (o_tx_c2_tid[p]),
      .o_c2_data          (o_tx_c2_data[p]),
      .o_mmio_rd_cnt      (mmio_rd_cnt[p]),
      .o_mmio_wr_cnt      (mmio_wr_cnt[p]),
      .o_stray_rsp_cnt    (stray_rsp_cnt[p]),
      .o_proto_err        (proto_err[p])
    );
  end

endmodule

// File: tb/tb_ofs_plat_host_chan_ccip_multi_tie_off.sv
module tb_ofs_plat_host_chan_ccip_multi_tie_off;

  localparam int          NP  = 3;
  localparam int          LAT = 2;
  localparam int          CW  = 4;
  localparam logic [63:0] DFH = 64'h1000_0100_0000_0000;
  localparam logic [63:0] DEF = 64'hDEAD_BEEF_CAFE_F00D;

`ifdef OFS_PLAT_HOST_CHAN_TIE_OFF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                   clk;
  logic                   reset;
  logic [NP-1:0]          rd_v, wr_v, c0_rsp, c1_rsp;
  logic [NP-1:0][8:0]     tid_in;
  logic [NP-1:0][15:0]    addr_in;
  logic [NP-1:0]          c0_v, c1_v, c2_v;
  logic [NP-1:0][8:0]     c2_tid;
  logic [NP-1:0][63:0]    c2_data;
  logic [NP-1:0][CW-1:0]  rd_cnt, wr_cnt, stray_cnt;
  logic [NP-1:0]          perr;

  int n_pass  = 0;
  int n_total = 0;

  ofs_plat_host_chan_ccip_multi_tie_off #(
    .NUM_PORTS       (NP),
    .RSP_LATENCY     (LAT),
    .DFH_VALUE       (DFH),
    .DEFAULT_RD_DATA (DEF),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .i_rx_c0_mmio_rd_valid (rd_v),
    .i_rx_c0_mmio_wr_valid (wr_v),
    .i_rx_c0_tid           (tid_in),
    .i_rx_c0_addr          (addr_in),
    .i_rx_c0_rsp_valid     (c0_rsp),
    .i_rx_c1_rsp_valid     (c1_rsp),
    .o_tx_c0_valid         (c0_v),
    .o_tx_c1_valid         (c1_v),
    .o_tx_c2_mmio_rd_valid (c2_v),
    .o_tx_c2_tid           (c2_tid),
    .o_tx_c2_data          (c2_data),
    .mmio_rd_cnt           (rd_cnt),
    .mmio_wr_cnt           (wr_cnt),
    .stray_rsp_cnt         (stray_cnt),
    .proto_err             (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected statistics value: the counters read 0 when compiled out.
  function automatic logic [63:0] st(input logic [63:0] v);
    return STATS ? v : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    rd_v    = '0;
    wr_v    = '0;
    c0_rsp  = '0;
    c1_rsp  = '0;
    tid_in  = '0;
    addr_in = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    tick();
    tick();

    // Reset state
    chk("rst_c2_valid", 64'(c2_v), 64'd0);
    chk("rst_c2_tid0", 64'(c2_tid[0]), 64'd0);
    chk("rst_c2_data0", c2_data[0], 64'd0);
    chk("rst_c0c1_valid", 64'({c0_v, c1_v}), 64'd0);
    chk("rst_rd_cnt0", 64'(rd_cnt[0]), 64'd0);
    chk("rst_proto_err", 64'(perr), 64'd0);
    reset = 1'b0;
    tick();

    // Single read, tid 5, addr 0 -> DFH after exactly LAT cycles
    rd_v[0] = 1'b1; tid_in[0] = 9'h005; addr_in[0] = 16'h0000;
    tick();
    clr_in();
    chk("single_not_early", 64'(c2_v), 64'd0);
    tick();
    chk("single_valid", 64'(c2_v), 64'b001);
    chk("single_tid", 64'(c2_tid[0]), 64'h5);
    chk("single_data", c2_data[0], DFH);
    tick();
    chk("single_one_cycle", 64'(c2_v), 64'd0);
    chk("single_rd_cnt", 64'(rd_cnt[0]), st(64'd1));

    // Eight back-to-back reads, tids 0..7, addr 0x10 -> default data in order
    for (int k = 0; k < 10; k++) begin
      clr_in();
      if (k < 8) begin
        rd_v[0] = 1'b1; tid_in[0] = 9'(k); addr_in[0] = 16'h0010;
      end
      if (k >= 2) begin
        chk("b2b_valid", 64'(c2_v), 64'b001);
        chk("b2b_tid", 64'(c2_tid[0]), 64'(k - 2));
        chk("b2b_data", c2_data[0], DEF);
      end else begin
        chk("b2b_idle", 64'(c2_v), 64'd0);
      end
      tick();
    end
    clr_in();
    chk("b2b_drained", 64'(c2_v), 64'd0);
    chk("b2b_rd_cnt", 64'(rd_cnt[0]), st(64'd9));

    // Port 2: write addr 0, then read addr 1 (DFH) and addr 2 (default)
    wr_v[2] = 1'b1; addr_in[2] = 16'h0000;
    tick();
    clr_in();
    rd_v[2] = 1'b1; tid_in[2] = 9'h003; addr_in[2] = 16'h0001;
    chk("wr_no_rsp_a", 64'(c2_v), 64'd0);
    tick();
    clr_in();
    rd_v[2] = 1'b1; tid_in[2] = 9'h1AB; addr_in[2] = 16'h0002;
    chk("wr_no_rsp_b", 64'(c2_v), 64'd0);
    tick();
    clr_in();
    chk("p2_rd1_valid", 64'(c2_v), 64'b100);
    chk("p2_rd1_tid", 64'(c2_tid[2]), 64'h3);
    chk("p2_rd1_data", c2_data[2], DFH);
    tick();
    chk("p2_rd2_valid", 64'(c2_v), 64'b100);
    chk("p2_rd2_tid", 64'(c2_tid[2]), 64'h1AB);
    chk("p2_rd2_data", c2_data[2], DEF);
    tick();
    chk("p2_idle", 64'(c2_v), 64'd0);
    chk("p2_wr_cnt", 64'(wr_cnt[2]), st(64'd1));
    chk("p2_rd_cnt", 64'(rd_cnt[2]), st(64'd2));

    // Stray c1 response on port 1 -> sticky proto_err
    chk("perr_before", 64'(perr), 64'd0);
    c1_rsp[1] = 1'b1;
    tick();
    clr_in();
    chk("perr_set", 64'(perr), st(64'b010));
    chk("stray_cnt1", 64'(stray_cnt[1]), st(64'd1));
    tick();
    tick();
    tick();
    chk("perr_sticky", 64'(perr), st(64'b010));
    c0_rsp[1] = 1'b1; c1_rsp[1] = 1'b1;
    tick();
    clr_in();
    chk("stray_cnt_dual", 64'(stray_cnt[1]), st(64'd3));
    chk("stray_no_mem_req", 64'({c0_v, c1_v}), 64'd0);
    chk("stray_other_ports", 64'(stray_cnt[0]), 64'd0);

    // Twenty writes on port 1 -> 4-bit counter saturates at F
    for (int k = 0; k < 20; k++) begin
      wr_v[1] = 1'b1; addr_in[1] = 16'h0000;
      tick();
    end
    clr_in();
    chk("wr_cnt_sat", 64'(wr_cnt[1]), st(64'hF));
    chk("wr_no_c2", 64'(c2_v), 64'd0);

    // Simultaneous read+write on port 0: read answered, both counted
    rd_v[0] = 1'b1; wr_v[0] = 1'b1; tid_in[0] = 9'h022; addr_in[0] = 16'h0004;
    tick();
    clr_in();
    tick();
    chk("rw_valid", 64'(c2_v), 64'b001);
    chk("rw_tid", 64'(c2_tid[0]), 64'h22);
    chk("rw_data", c2_data[0], DEF);
    chk("rw_rd_cnt", 64'(rd_cnt[0]), st(64'd10));
    chk("rw_wr_cnt", 64'(wr_cnt[0]), st(64'd1));

    // Reset one cycle after a read with tid 1FF: response discarded
    tick();
    rd_v[0] = 1'b1; tid_in[0] = 9'h1FF; addr_in[0] = 16'h0000;
    tick();
    clr_in();
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(c2_v), 64'd0);
    chk("mid_rst_tid", 64'(c2_tid[0]), 64'd0);
    chk("mid_rst_rd_cnt", 64'(rd_cnt[0]), 64'd0);
    chk("mid_rst_wr_cnt", 64'(wr_cnt[1]), 64'd0);
    chk("mid_rst_stray", 64'(stray_cnt[1]), 64'd0);
    chk("mid_rst_perr", 64'(perr), 64'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_no_rsp", 64'(c2_v), 64'd0);
      chk("post_rst_tid", 64'(c2_tid[0]), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ofs_plat_host_chan_ccip_multi_tie_off.md
# ofs_plat_host_chan_ccip_multi_tie_off

Ties off an array of unused native CCI-P host channel ports on the FIU side and, unlike a passive tie-off, answers every MMIO read. Offset 0 returns a null AFU DFH (end-of-list set) and all other offsets return a fixed value, so software enumeration and stray reads never time out. Per-port statistics and a sticky protocol-error flag are compiled in optionally. The block is instantiated by the platform top level for each group of host channels the AFU leaves unused.

## Interface
- NUM_PORTS, 1: number of tied-off ports (≥1).
- RSP_LATENCY, 2: cycles from MMIO read request to `mmioRdValid` response (1..8).
- DFH_VALUE, 64'h1000_0100_0000_0000: data returned for a read at DWORD address 0 or 1 (feature type AFU, EOL=1, next=0).
- DEFAULT_RD_DATA, 64'h0: data returned for all other addresses.
- CNT_WIDTH, 32: width of each statistics counter.
- clk  input  1  clock shared by all ports.
- reset  input  1  asynchronous, active-high.
- port  ofs_plat_host_ccip_if.to_fiu  [NUM_PORTS]  tied-off channels.
- mmio_rd_cnt  output  NUM_PORTS×CNT_WIDTH  MMIO reads answered per port.
- mmio_wr_cnt  output  NUM_PORTS×CNT_WIDTH  MMIO writes absorbed per port.
- stray_rsp_cnt  output  NUM_PORTS×CNT_WIDTH  unexpected c0/c1 responses per port.
- proto_err  output  NUM_PORTS  sticky; set on any stray response.

## Operation
- `sTx.c0.valid` and `sTx.c1.valid` are constant 0. No memory requests are ever issued.
- MMIO write (`sRx.c0.mmioWrValid`): data discarded. Write counter increments.
- MMIO read (`sRx.c0.mmioRdValid`): capture `tid` (9b) and `address` (16b, DWORD units) from the c0 MMIO request header.
  - Data select: address[15:1]==0 → DFH_VALUE, else DEFAULT_RD_DATA.
  - The select applies to all lengths (4B/8B/64B); the response carries 64 bits.
  - Response: `sTx.c2.mmioRdValid`=1, `hdr.tid`=captured tid, `data`=selected value, emitted exactly RSP_LATENCY cycles after the request.
- Back-to-back reads: one per cycle, sustained indefinitely. Each is answered in order with its own tid. There is no buffering limit, because the fixed-latency shift register has exactly RSP_LATENCY slots.
- `sRx.c0.rspValid` or `sRx.c1.rspValid`: stray response.
  - Stray counter increments.
  - `proto_err` for that port sets, and clears only on reset.
- Counters saturate at all-ones and never wrap.
- A c0 stray and c1 stray in the same cycle increment the stray counter by 2 (saturating).
- Simultaneous MMIO read and write flags on one cycle are illegal on CCI-P. The block must not hang: it answers the read and counts both.
- Ports are fully independent. There is no shared state.

## Timing
- Reset values: all `sTx` valid bits 0, c2 hdr/data 0, all counters 0, `proto_err` 0.
- Reset asserted mid-operation:
  - In-flight read responses are discarded and are not replayed after reset.
  - Outputs go to their reset values asynchronously.
- The response path is registered: `sTx.c2` is driven from flops. There is no combinational path from `sRx` to `sTx`.
- Counters and `proto_err` update one cycle after the triggering event.
- Request at cycle N → `mmioRdValid` high in cycle N+RSP_LATENCY, for exactly one cycle.

## Configuration
- `OFS_PLAT_HOST_CHAN_TIE_OFF_STATS_EN` defined:
  - Counters and `proto_err` are implemented as described above.
- Undefined:
  - The statistics outputs remain as ports but are driven constant 0.
  - No counter flops are instantiated.
  - MMIO response behaviour is unchanged.

## Structure
- Package `ofs_plat_host_chan_tie_off_pkg` holds:
  - the default DFH constant;
  - the address-match helper function;
  - the response pipeline entry struct (valid, tid, data).
- Sub-module `ofs_plat_host_chan_ccip_tie_off_port`:
  - handles one port: response shift register plus statistics;
  - the top level generates NUM_PORTS instances.

## Test plan
- Single read, tid=9'h05, addr=0, RSP_LATENCY=2 → c2 `mmioRdValid` at N+2, tid 5, data 64'h1000_0100_0000_0000.
- Eight consecutive reads, tids 0..7, addr 16'h0010 → eight consecutive responses in order, data 0, tids 0..7, rd_cnt=8.
- MMIO write to addr 0 followed by a read → write counter=1, read still returns DFH_VALUE, no extra c2 valid.
- `sRx.c1.rspValid` pulse on port 1 of NUM_PORTS=3 → `proto_err`=3'b010 next cycle, stray_rsp_cnt[1]=1, stays set until reset.
- Reset asserted one cycle after a read with tid 9'h1FF → no response ever appears for that tid, all outputs 0.
- CNT_WIDTH=4, 20 writes → mmio_wr_cnt saturates at 4'hF. With the macro undefined, all statistics outputs read 0.
